// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 1R1W SRAM with a 2-entry registered output buffer.
// Define SRAM_FIFO_BYPASS_EN to let words skip the SRAM when the FIFO is nearly empty.
module sram_fifo_ctrl #(
    parameter int WWORD = 96,
    parameter int DEPTH = 1024,
    parameter int WADDR = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WWORD-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WWORD-1:0] out_data,
    output logic [WADDR+1:0] level,
    output logic [WADDR-1:0] mem_aa,
    output logic             mem_cena,
    input  logic [WWORD-1:0] mem_qa,
    output logic [WADDR-1:0] mem_ab,
    output logic [WWORD-1:0] mem_db,
    output logic             mem_cenb
);

    localparam logic [WADDR:0] FULL = (WADDR+1)'(DEPTH);

    logic [WADDR-1:0] wptr;
    logic [WADDR-1:0] rptr;
    logic [WADDR:0]   mem_cnt;
    logic [1:0]       ob_cnt;
    logic             inflight;
    logic             run;
    logic [WWORD-1:0] ob0;
    logic [WWORD-1:0] ob1;

    logic             wr;
    logic             wr_mem;
    logic             rd;
    logic             pop;
    logic             byp;
    logic             push;
    logic [WWORD-1:0] push_data;
    logic [2:0]       occ;

    // run holds off all SRAM traffic until one edge after reset release
    assign in_ready  = run && (mem_cnt != FULL) && !clear;
    assign wr        = in_valid && in_ready;
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob0;
    assign pop       = out_valid && out_ready;
    assign occ       = {1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rd        = run && (mem_cnt != '0) && (occ < 3'd2) && !clear;

`ifdef SRAM_FIFO_BYPASS_EN
    assign byp = wr && (mem_cnt == '0) && !inflight && (ob_cnt != 2'd2);
`else
    assign byp = 1'b0;
`endif

    assign wr_mem    = wr && !byp;
    assign push      = inflight || byp;
    assign push_data = inflight ? mem_qa : in_data;

    assign mem_cenb = !wr_mem;
    assign mem_ab   = wptr;
    assign mem_db   = in_data;
    assign mem_cena = !rd;
    assign mem_aa   = rptr;

    assign level = {1'b0, mem_cnt} + (WADDR+2)'(inflight) + (WADDR+2)'(ob_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run      <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            ob_cnt   <= 2'd0;
            inflight <= 1'b0;
            ob0      <= '0;
            ob1      <= '0;
        end else begin
            run <= 1'b1;
            if (clear) begin
                wptr     <= '0;
                rptr     <= '0;
                mem_cnt  <= '0;
                ob_cnt   <= 2'd0;
                inflight <= 1'b0;
            end else begin
                if (wr_mem) wptr <= wptr + WADDR'(1);
                if (rd) rptr <= rptr + WADDR'(1);
                mem_cnt  <= mem_cnt + (WADDR+1)'(wr_mem) - (WADDR+1)'(rd);
                inflight <= rd;
                // pop shifts the buffer; push appends behind whatever remains
                if (push && pop) begin
                    if (ob_cnt == 2'd2) begin
                        ob0 <= ob1;
                        ob1 <= push_data;
                    end else begin
                        ob0 <= push_data;
                    end
                end else if (push) begin
                    if (ob_cnt == 2'd0) ob0 <= push_data;
                    else ob1 <= push_data;
                    ob_cnt <= ob_cnt + 2'd1;
                end else if (pop) begin
                    ob0    <= ob1;
                    ob_cnt <= ob_cnt - 2'd1;
                end
            end
        end
    end

endmodule
